// File: rtl/jk_bank_ctrl_pkg.sv
// Shared encodings for the JK bank controller: command opcodes and FSM states.
// Every file that decodes commands or walks the FSM imports this package.
package jk_bank_ctrl_pkg;

    typedef enum logic [1:0] {
        OP_HOLD  = 2'b00,
        OP_LOAD  = 2'b01,
        OP_COUNT = 2'b10,
        OP_CLEAR = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_DONE = 2'b10
    } state_e;

endpackage

// File: rtl/jk_bank_ctrl_cell.sv
// Single JK flip-flop with synchronous active-low reset.
// It is replicated once per bit of the controlled bank.
module jk_cell (
    input  logic clk,
    input  logic rst_n,
    input  logic j,
    input  logic k,
    output logic q
);

    logic q_r;

    // JK storage: hold, clear, set or toggle according to {j,k}
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q_r <= 1'b0;
        end else begin
            case ({j, k})
                2'b00:   q_r <= q_r;
                2'b01:   q_r <= 1'b0;
                2'b10:   q_r <= 1'b1;
                2'b11:   q_r <= ~q_r;
                default: q_r <= q_r;
            endcase
        end
    end

    assign q = q_r;

endmodule

// File: rtl/jk_bank_ctrl.sv
// Command-driven sequencer for a bank of JK flip-flops: HOLD/LOAD/CLEAR/COUNT
// through a valid/ready handshake, with done and wrap pulses.
module jk_bank_ctrl
    import jk_bank_ctrl_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic [LEN_W-1:0] cmd_len,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             done,
    output logic             wrap
);

    state_e             state_r;
    state_e             state_nxt_s;
    op_e                op_r;
    logic [WIDTH-1:0]   data_r;
    logic [LEN_W-1:0]   len_r;
    logic [LEN_W-1:0]   step_r;
    logic               wrap_r;
    logic               accept_s;
    logic               last_step_s;
    logic               zero_count_s;
    logic [WIDTH-1:0]   j_s;
    logic [WIDTH-1:0]   k_s;
    logic [WIDTH-1:0]   carry_s;
    logic [WIDTH-1:0]   q_s;

    assign accept_s     = cmd_valid && (state_r == ST_IDLE);
    assign zero_count_s = (op_e'(cmd_op) == OP_COUNT) && (cmd_len == {LEN_W{1'b0}});
    assign last_step_s  = (step_r == (len_r - LEN_W'(1)));

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state decode; a zero-length COUNT skips EXEC entirely
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    if (zero_count_s) begin
                        state_nxt_s = ST_DONE;
                    end else begin
                        state_nxt_s = ST_EXEC;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_EXEC: begin
                if ((op_r != OP_COUNT) || last_step_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_EXEC;
                end
            end
            ST_DONE: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Command latch and EXEC step counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_r   <= OP_HOLD;
            data_r <= {WIDTH{1'b0}};
            len_r  <= {LEN_W{1'b0}};
            step_r <= {LEN_W{1'b0}};
        end else if (accept_s) begin
            op_r   <= op_e'(cmd_op);
            data_r <= cmd_data;
            len_r  <= cmd_len;
            step_r <= {LEN_W{1'b0}};
        end else if (state_r == ST_EXEC) begin
            op_r   <= op_r;
            data_r <= data_r;
            len_r  <= len_r;
            step_r <= step_r + LEN_W'(1);
        end else begin
            op_r   <= op_r;
            data_r <= data_r;
            len_r  <= len_r;
            step_r <= step_r;
        end
    end

    // Ripple of "all lower bits set" forms the up-counter toggle enables
    always_comb begin
        carry_s    = {WIDTH{1'b0}};
        carry_s[0] = 1'b1;
        for (int i = 1; i < WIDTH; i++) begin
            carry_s[i] = carry_s[i-1] & q_s[i-1];
        end
    end

    // FSM outputs: handshake flags and the bank's J/K drive
    always_comb begin
        j_s       = {WIDTH{1'b0}};
        k_s       = {WIDTH{1'b0}};
        cmd_ready = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                cmd_ready = 1'b1;
            end
            ST_EXEC: begin
                busy = 1'b1;
                case (op_r)
                    OP_HOLD: begin
                        j_s = {WIDTH{1'b0}};
                        k_s = {WIDTH{1'b0}};
                    end
                    OP_LOAD: begin
                        j_s = data_r;
                        k_s = ~data_r;
                    end
                    OP_COUNT: begin
                        j_s = carry_s;
                        k_s = carry_s;
                    end
                    OP_CLEAR: begin
                        j_s = {WIDTH{1'b0}};
                        k_s = {WIDTH{1'b1}};
                    end
                    default: begin
                        j_s = {WIDTH{1'b0}};
                        k_s = {WIDTH{1'b0}};
                    end
                endcase
            end
            ST_DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: begin
                cmd_ready = 1'b0;
            end
        endcase
    end

    // Wrap pulse: flags the count step that rolls all-ones over to zero
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wrap_r <= 1'b0;
        end else begin
            wrap_r <= (state_r == ST_EXEC) && (op_r == OP_COUNT) && (q_s == {WIDTH{1'b1}});
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_cell
            jk_cell u_cell (
                .clk   (clk),
                .rst_n (rst_n),
                .j     (j_s[gi]),
                .k     (k_s[gi]),
                .q     (q_s[gi])
            );
        end
    endgenerate

    assign q    = q_s;
    assign wrap = wrap_r;

endmodule
